acc_drain: RTL and testbench

ACC_DRAIN -- requirements
Module: acc_drain

---
 rtl/acc_drain_pkg.sv | 22 ++
 rtl/acc_drain_if.sv | 18 +
 rtl/acc_drain_buf.sv | 37 +++
 rtl/acc_drain.sv | 113 +++++++++++
 tb/tb_acc_drain.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/acc_drain_pkg.sv
// acc_drain_pkg: shared state encoding, default sizes and the index-width
// helper used by the accumulator drain block and its interface.
package acc_drain_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_C_WIDTH = 32;
    localparam int DEF_K_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        CTRL   = 3'd2,
        SETTLE = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    // Width of a word index; a single-entry bank still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_drain_if.sv
// acc_drain_if: drained-word stream from acc_drain to its consumer.
// Handshake: a word (out_data, out_idx) is transferred on every rising clk
// edge where out_valid and out_ready are both high; while out_valid is high
// and out_ready is low the producer holds out_data and out_idx stable.
interface acc_drain_if
    import acc_drain_pkg::*;
#(
    parameter int C_WIDTH = DEF_C_WIDTH,
    parameter int IW      = idx_width(DEF_N)
);
    logic [C_WIDTH-1:0] out_data;
    logic [IW-1:0]      out_idx;
    logic               out_valid;
    logic               out_ready;

    modport master (output out_data, output out_idx, output out_valid, input out_ready);
    modport slave  (input out_data, input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/acc_drain_buf.sv
// acc_drain_buf: N-entry shadow bank that snapshots the PE accumulators in
// one parallel load and presents the entry selected by idx.
module acc_drain_buf
    import acc_drain_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int C_WIDTH = DEF_C_WIDTH,
    parameter int IW      = idx_width(DEF_N)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load,
    input  logic [N*C_WIDTH-1:0] in_c,
    input  logic [IW-1:0]        idx,
    output logic [C_WIDTH-1:0]   word
);

    logic [C_WIDTH-1:0] bank [N];

    // Parallel capture of all N accumulator words when load is asserted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) bank[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < N; i++) bank[i] <= in_c[i*C_WIDTH +: C_WIDTH];
        end
    end

    // Read mux; decoded compare keeps non-power-of-two N free of out-of-range reads.
    always_comb begin
        word = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) word = bank[i];
        end
    end

endmodule

// File: rtl/acc_drain.sv
// acc_drain: runs one tile (k_len MAC cycles), strobes pe_control to make the
// PEs present their accumulators, snapshots them, then drains the N words one
// per accepted handshake and pulses done.
// Build option: define ACC_DRAIN_RELU_EN to clamp negative (signed) words to
// zero on out_data; the shadow bank always keeps the raw value.
module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int C_WIDTH = DEF_C_WIDTH,
    parameter int K_WIDTH = DEF_K_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [K_WIDTH-1:0]   k_len,
    output logic                 pe_control,
    input  logic [N*C_WIDTH-1:0] in_c,
    output logic                 busy,
    output logic                 done,
    output state_t               fsm_state,
    acc_drain_if.master          drain
);

    localparam int IW = idx_width(N);

    state_t             state;
    state_t             nxt;
    logic [K_WIDTH-1:0] cnt;
    logic [IW-1:0]      idx;
    logic               load;
    logic               out_valid;
    logic               fire;
    logic               last;
    logic [C_WIDTH-1:0] raw_word;

    assign fire      = out_valid && drain.out_ready;
    assign last      = (idx == IW'(N - 1));
    assign fsm_state = state;

    // Next-state and per-state outputs.
    always_comb begin
        nxt        = state;
        pe_control = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        load       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) nxt = RUN;
            end
            RUN: begin
                if (cnt <= K_WIDTH'(1)) nxt = CTRL;
            end
            CTRL: begin
                pe_control = 1'b1;
                nxt        = SETTLE;
            end
            SETTLE: begin
                load = 1'b1;
                nxt  = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (fire && last) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // State register, MAC cycle counter, drain index and done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            done  <= (state == DRAIN) && fire && last;
            case (state)
                IDLE:    if (start) cnt <= (k_len == '0) ? K_WIDTH'(1) : k_len;
                RUN:     cnt <= cnt - K_WIDTH'(1);
                SETTLE:  idx <= '0;
                DRAIN:   if (fire && !last) idx <= idx + IW'(1);
                default: ;
            endcase
        end
    end

    acc_drain_buf #(
        .N       (N),
        .C_WIDTH (C_WIDTH),
        .IW      (IW)
    ) u_buf (
        .clk  (clk),
        .rstn (rstn),
        .load (load),
        .in_c (in_c),
        .idx  (idx),
        .word (raw_word)
    );

    assign drain.out_valid = out_valid;
    assign drain.out_idx   = idx;
`ifdef ACC_DRAIN_RELU_EN
    assign drain.out_data  = raw_word[C_WIDTH-1] ? '0 : raw_word;
`else
    assign drain.out_data  = raw_word;
`endif

endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: directed and randomized tile runs against a timeline/queue
// model of acc_drain (build option ACC_DRAIN_RELU_EN mirrored in the model).
module tb_acc_drain;
    import acc_drain_pkg::*;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int KW = 16;
    localparam int IW = idx_width(N);

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic [KW-1:0]   k_len = '0;
    logic [N*CW-1:0] in_c = '0;
    logic            pe_control;
    logic            busy;
    logic            done;
    state_t          fsm_state;

    acc_drain_if #(.C_WIDTH(CW), .IW(IW)) drain_bus ();

    acc_drain #(.N(N), .C_WIDTH(CW), .K_WIDTH(KW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .k_len      (k_len),
        .pe_control (pe_control),
        .in_c       (in_c),
        .busy       (busy),
        .done       (done),
        .fsm_state  (fsm_state),
        .drain      (drain_bus.master)
    );

    // Clock
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [CW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of what the consumer should see for one buffered word.
    function automatic logic [CW-1:0] model_word(input logic [CW-1:0] w);
`ifdef ACC_DRAIN_RELU_EN
        return ($signed(w) < 0) ? '0 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [N*CW-1:0] rand_words();
        logic [N*CW-1:0] v;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = $urandom;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pe"},    64'(pe_control),          64'd0);
        check({tag, "_valid"}, 64'(drain_bus.out_valid), 64'd0);
        check({tag, "_done"},  64'(done),                64'd0);
        check({tag, "_busy"},  64'(busy),                64'd0);
        check({tag, "_data"},  64'(drain_bus.out_data),  64'd0);
        check({tag, "_idx"},   64'(drain_bus.out_idx),   64'd0);
    endtask

    // One tile. Called at a negedge; start is driven immediately.
    // mode: 0 always ready, 1 random ready, 2 five-cycle stall at idx 1.
    // poke: pulse start in RUN and in DRAIN. abort_idx: assert reset at that idx.
    // b2b: return in the done cycle so the next call starts there.
    task automatic run_tile(input int k, input logic [N*CW-1:0] words, input int mode,
                            input bit poke, input int abort_idx, input bit b2b);
        int cyc, acc, stall, dcyc, kk;
        logic rdy;
        kk = (k == 0) ? 1 : k;
        start = 1'b1;
        k_len = KW'(k);
        in_c  = rand_words();
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(model_word(words[i*CW +: CW]));
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        // RUN phase: in_c churns, must not matter.
        while (pe_control !== 1'b1 && cyc < 100) begin
            check("run_busy", 64'(busy), 64'd1);
            start = (poke && cyc == 1) ? 1'b1 : 1'b0;
            in_c  = rand_words();
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("ctrl_cycle", 64'(cyc), 64'(kk + 1));
        check("ctrl_valid", 64'(drain_bus.out_valid), 64'd0);
        @(negedge clk);
        check("settle_pe", 64'(pe_control), 64'd0);
        check("settle_valid", 64'(drain_bus.out_valid), 64'd0);
        check("settle_busy", 64'(busy), 64'd1);
        in_c = words;
        @(negedge clk);
        in_c = rand_words();
        acc = 0; stall = 0; dcyc = 0;
        while (acc < N && dcyc < 200) begin
            check("drain_valid", 64'(drain_bus.out_valid), 64'd1);
            check("drain_data", 64'(drain_bus.out_data), 64'(exp_q[0]));
            check("drain_idx", 64'(drain_bus.out_idx), 64'(acc));
            check("drain_pe", 64'(pe_control), 64'd0);
            if (acc == abort_idx) begin
                drain_bus.out_ready = 1'b0;
                start = 1'b0;
                rstn = 1'b0;
                #1;
                check_reset_outputs("abort");
                check("abort_state", 64'(fsm_state), 64'(IDLE));
                repeat (2) begin
                    @(negedge clk);
                    check("abort_no_done", 64'(done), 64'd0);
                end
                return;
            end
            case (mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = !(acc == 1 && stall < 5);
                default: rdy = 1'b1;
            endcase
            if (mode == 2 && !rdy) stall++;
            drain_bus.out_ready = rdy;
            start = (poke && dcyc == 0) ? 1'b1 : 1'b0;
            if (rdy) begin
                void'(exp_q.pop_front());
                acc++;
            end
            @(negedge clk);
            dcyc++;
        end
        drain_bus.out_ready = 1'b0;
        start = 1'b0;
        check("drain_accepted", 64'(acc), 64'(N));
        if (mode == 0) check("drain_cycles", 64'(dcyc), 64'(N));
        if (mode == 2) check("drain_stall_cycles", 64'(dcyc), 64'(N + 5));
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_valid", 64'(drain_bus.out_valid), 64'd0);
        if (b2b) return;
        repeat (3) begin
            @(negedge clk);
            check("after_done", 64'(done), 64'd0);
            check("after_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic [N*CW-1:0] w;
        drain_bus.out_ready = 1'b0;

        // Reset state
        #12;
        check_reset_outputs("reset");
        check("reset_state", 64'(fsm_state), 64'(IDLE));

        // Basic run: release reset and start together, always ready.
        @(negedge clk);
        rstn = 1'b1;
        w = {32'd40, 32'd30, 32'd20, 32'd10};
        run_tile(3, w, 0, 1'b0, -1, 1'b0);

        // Backpressure at idx 1.
        run_tile(2, w, 2, 1'b0, -1, 1'b0);

        // k_len = 0 behaves as 1.
        run_tile(0, rand_words(), 0, 1'b0, -1, 1'b0);

        // Stray start pulses in RUN and DRAIN.
        run_tile(5, rand_words(), 0, 1'b1, -1, 1'b0);

        // Reset in DRAIN at idx 2, then a clean run right at release.
        run_tile(4, w, 0, 1'b0, 2, 1'b0);
        rstn = 1'b1;
        run_tile(1, rand_words(), 0, 1'b0, -1, 1'b0);

        // Negative word 0, then a run started in the done cycle.
        w = rand_words();
        w[CW-1:0] = 32'hFFFF_FFF6;
        run_tile(1, w, 0, 1'b0, -1, 1'b1);
        run_tile(2, rand_words(), 1, 1'b0, -1, 1'b0);

        // Randomized tiles.
        for (int r = 0; r < 8; r++) begin
            run_tile($urandom_range(0, 6), rand_words(), $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                     -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
